// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a DEPTH-entry prefetch queue.
// Optional build macro INSTR_FETCH_BYPASS_EN forwards an ack straight to the consumer when the queue is empty.
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [1:0]  op,
  output logic [3:0]  cond,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  output logic [3:0]  instr74
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e        state_q;
  logic          req_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic ack_wait, queue_empty, bypass, pop, pop_q, push;

  assign ack_wait    = (state_q == WAIT) && imem_ack;
  assign queue_empty = (count_q == '0);

`ifdef INSTR_FETCH_BYPASS_EN
  assign bypass   = queue_empty && ack_wait && !pc_src;
  assign instr    = bypass ? imem_rdata : q_instr_q[rd_ptr_q];
  assign instr_pc = bypass ? fetch_pc_q : q_pc_q[rd_ptr_q];
`else
  assign bypass   = 1'b0;
  assign instr    = q_instr_q[rd_ptr_q];
  assign instr_pc = q_pc_q[rd_ptr_q];
`endif

  assign instr_valid = !queue_empty || bypass;
  assign pop         = instr_valid && instr_ready;
  // A forwarded word that the consumer takes right away never enters the queue.
  assign pop_q       = pop && !queue_empty && !pc_src;
  assign push        = ack_wait && !pc_src && !(bypass && instr_ready);
  assign count_d     = count_q + CW'(push) - CW'(pop_q);

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;

  assign op      = instr[27:26];
  assign cond    = instr[31:28];
  assign funct   = instr[25:20];
  assign rd      = instr[15:12];
  assign instr74 = instr[7:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      // NOTE: the queue storage is reset so instr/instr_pc read zero out of reset; only valid for small DEPTH.
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      if (pc_src) begin
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fetch_pc_q <= pc_target & ~32'h3;
      end else begin
        count_q <= count_d;
        if (push) begin
          q_instr_q[wr_ptr_q] <= imem_rdata;
          q_pc_q[wr_ptr_q]    <= fetch_pc_q;
          wr_ptr_q            <= wr_ptr_q + PW'(1);
        end
        if (pop_q)    rd_ptr_q   <= rd_ptr_q + PW'(1);
        if (ack_wait) fetch_pc_q <= fetch_pc_q + 32'd4;
      end

      unique case (state_q)
        IDLE: begin
          if (!pc_src && (count_q < FULL)) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (pc_src) begin
            state_q <= imem_ack ? IDLE : DROP;
            req_q   <= 1'b0;
          end else if (imem_ack && !(count_d < FULL)) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        // The stale response still has to drain; further redirects only move fetch_pc_q.
        DROP: begin
          if (imem_ack) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
